// File: rtl/tcp_pkg.sv
// Shared TCP types for the RX and TX control blocks.
// Holds the TX request encoding, flag bit map and RX state encoding.
package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_SEND_SYN    = 3'd0,
    TX_CTRL_SEND_SYNACK = 3'd1,
    TX_CTRL_SEND_ACK    = 3'd2,
    TX_CTRL_SEND_FIN    = 3'd3,
    TX_CTRL_SEND_RST    = 3'd4
  } tx_ctrl_t;

  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_CHECK   = 3'd1,
    RX_FORWARD = 3'd2,
    RX_DROP    = 3'd3,
    RX_REQ_ACK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/axis_intf.sv
// Minimal AXI-Stream payload interface.
// The master drives data/valid/last and the slave drives ready.
interface axis_intf #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport MASTER (output tdata, tvalid, tlast, input tready);
  modport SLAVE  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/tcp_rx_ctrl.sv
// Receive-side TCP control: tracks RCV.NXT, forwards in-order payload,
// drops unacceptable segments and requests ACKs from TX control.
module tcp_rx_ctrl
  import tcp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_seq_number,
  input  logic [31:0] i_ack_number,
  input  logic [7:0]  i_flags,
  input  logic [15:0] i_window_size,
  input  logic [15:0] i_payload_len,
  input  logic        i_hdr_valid,
  output logic        o_hdr_ack,
  axis_intf.SLAVE     s_axis,
  axis_intf.MASTER    m_axis,
  output tx_ctrl_t    o_tx_ctrl,
  output logic        o_tx_ctrl_valid,
  input  logic        i_tx_ctrl_ack,
  output logic [31:0] o_ack_number,
  output logic [31:0] o_peer_ack,
  output logic [15:0] o_peer_window,
  output logic        o_synced,
  output logic        o_syn_rcvd,
  output logic        o_fin_rcvd,
  output logic        o_rst_rcvd
);

  rx_state_t   r_state;
  rx_state_t   w_state_nxt;
  logic [31:0] r_rcv_nxt;
  logic        r_synced;
  logic [31:0] r_seq;
  logic [31:0] r_ack;
  logic [7:0]  r_flags;
  logic [15:0] r_win;
  logic [15:0] r_len;
  logic [31:0] r_peer_ack;
  logic [15:0] r_peer_win;
  logic        r_fin_pending;
  logic        r_ack_after;
  logic        w_ack_after_nxt;

  logic w_len0;
  logic w_rst;
  logic w_syn;
  logic w_in_ord;
  logic w_fwd_last;
  logic w_drop_last;
  logic w_unused;

  assign w_len0   = (r_len == 16'd0);
  assign w_rst    = r_flags[FLAG_RST];
  assign w_syn    = !w_rst && r_flags[FLAG_SYN];
  assign w_in_ord = !w_rst && !r_flags[FLAG_SYN] && r_synced &&
                    (r_seq == r_rcv_nxt);
  assign w_fwd_last  = s_axis.tvalid && m_axis.tready && s_axis.tlast;
  assign w_drop_last = s_axis.tvalid && s_axis.tlast;
  assign w_unused    = ^{r_flags[7:5], r_flags[FLAG_PSH]};

  assign o_ack_number  = r_rcv_nxt;
  assign o_peer_ack    = r_peer_ack;
  assign o_peer_window = r_peer_win;
  assign o_synced      = r_synced;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and ACK-after-drop decision.
  always_comb begin
    w_state_nxt     = r_state;
    w_ack_after_nxt = r_ack_after;
    unique case (r_state)
      RX_IDLE: begin
        if (i_hdr_valid) w_state_nxt = RX_CHECK;
      end
      RX_CHECK: begin
        w_ack_after_nxt = 1'b0;
        if (w_rst) begin
          w_state_nxt = w_len0 ? RX_IDLE : RX_DROP;
        end else if (w_syn) begin
          w_state_nxt     = w_len0 ? RX_REQ_ACK : RX_DROP;
          w_ack_after_nxt = 1'b1;
        end else if (!r_synced) begin
          w_state_nxt = w_len0 ? RX_IDLE : RX_DROP;
        end else if (!w_in_ord) begin
          if (!w_len0) begin
            w_state_nxt     = RX_DROP;
            w_ack_after_nxt = 1'b1;
          end else if (r_flags[FLAG_FIN]) begin
            w_state_nxt = RX_REQ_ACK;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end else if (!w_len0) begin
          w_state_nxt = RX_FORWARD;
        end else if (r_flags[FLAG_FIN]) begin
          w_state_nxt = RX_REQ_ACK;
        end else begin
          w_state_nxt = RX_IDLE;
        end
      end
      RX_FORWARD: begin
        if (w_fwd_last) w_state_nxt = RX_REQ_ACK;
      end
      RX_DROP: begin
        if (w_drop_last)
          w_state_nxt = r_ack_after ? RX_REQ_ACK : RX_IDLE;
      end
      RX_REQ_ACK: begin
        if (i_tx_ctrl_ack) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // Outputs: handshakes, passthrough, TX request and event pulses.
  always_comb begin
    o_hdr_ack       = 1'b0;
    s_axis.tready   = 1'b0;
    m_axis.tvalid   = 1'b0;
    m_axis.tdata    = '0;
    m_axis.tlast    = 1'b0;
    o_tx_ctrl       = TX_CTRL_SEND_SYN;
    o_tx_ctrl_valid = 1'b0;
    o_syn_rcvd      = 1'b0;
    o_fin_rcvd      = 1'b0;
    o_rst_rcvd      = 1'b0;
    unique case (r_state)
      RX_IDLE: o_hdr_ack = i_hdr_valid && !i_rst;
      RX_CHECK: begin
        o_rst_rcvd = w_rst;
        o_syn_rcvd = w_syn;
        o_fin_rcvd = w_in_ord && w_len0 && r_flags[FLAG_FIN];
      end
      RX_FORWARD: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        o_fin_rcvd    = w_fwd_last && r_fin_pending;
      end
      RX_DROP: s_axis.tready = 1'b1;
      RX_REQ_ACK: begin
        o_tx_ctrl       = TX_CTRL_SEND_ACK;
        o_tx_ctrl_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Header latch and sequence-space bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcv_nxt     <= '0;
      r_synced      <= 1'b0;
      r_seq         <= '0;
      r_ack         <= '0;
      r_flags       <= '0;
      r_win         <= '0;
      r_len         <= '0;
      r_peer_ack    <= '0;
      r_peer_win    <= '0;
      r_fin_pending <= 1'b0;
      r_ack_after   <= 1'b0;
    end else begin
      r_ack_after <= w_ack_after_nxt;
      if (r_state == RX_IDLE && i_hdr_valid) begin
        r_seq         <= i_seq_number;
        r_ack         <= i_ack_number;
        r_flags       <= i_flags;
        r_win         <= i_window_size;
        r_len         <= i_payload_len;
        r_fin_pending <= i_flags[FLAG_FIN];
      end
      if (r_state == RX_CHECK) begin
        if (w_rst) begin
          r_synced <= 1'b0;
        end else if (w_syn) begin
          r_rcv_nxt  <= r_seq + 32'd1;
          r_synced   <= 1'b1;
          r_peer_ack <= r_ack;
          r_peer_win <= r_win;
        end else if (w_in_ord) begin
          if (r_flags[FLAG_ACK]) begin
            r_peer_ack <= r_ack;
            r_peer_win <= r_win;
          end
          if (w_len0 && r_flags[FLAG_FIN])
            r_rcv_nxt <= r_rcv_nxt + 32'd1;
        end
      end
      if (r_state == RX_FORWARD && w_fwd_last)
        r_rcv_nxt <= r_rcv_nxt + {16'd0, r_len} +
                     {31'd0, r_fin_pending};
    end
  end

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Directed self-checking bench for tcp_rx_ctrl.
// Scenarios run in sequence from one initial block.
module tb_tcp_rx_ctrl;
  import tcp_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_seq_number;
  logic [31:0] i_ack_number;
  logic [7:0]  i_flags;
  logic [15:0] i_window_size;
  logic [15:0] i_payload_len;
  logic        i_hdr_valid;
  logic        o_hdr_ack;
  tx_ctrl_t    o_tx_ctrl;
  logic        o_tx_ctrl_valid;
  logic        i_tx_ctrl_ack;
  logic [31:0] o_ack_number;
  logic [31:0] o_peer_ack;
  logic [15:0] o_peer_window;
  logic        o_synced;
  logic        o_syn_rcvd;
  logic        o_fin_rcvd;
  logic        o_rst_rcvd;

  int n_chk = 0;
  int n_fail = 0;

  axis_intf #(.DATA_W(8)) s_if ();
  axis_intf #(.DATA_W(8)) m_if ();

  always #5 clk = ~clk;

  tcp_rx_ctrl dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_seq_number    (i_seq_number),
    .i_ack_number    (i_ack_number),
    .i_flags         (i_flags),
    .i_window_size   (i_window_size),
    .i_payload_len   (i_payload_len),
    .i_hdr_valid     (i_hdr_valid),
    .o_hdr_ack       (o_hdr_ack),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .o_tx_ctrl       (o_tx_ctrl),
    .o_tx_ctrl_valid (o_tx_ctrl_valid),
    .i_tx_ctrl_ack   (i_tx_ctrl_ack),
    .o_ack_number    (o_ack_number),
    .o_peer_ack      (o_peer_ack),
    .o_peer_window   (o_peer_window),
    .o_synced        (o_synced),
    .o_syn_rcvd      (o_syn_rcvd),
    .o_fin_rcvd      (o_fin_rcvd),
    .o_rst_rcvd      (o_rst_rcvd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [31:0] seq, input logic [31:0] ack,
                     input logic [7:0] fl, input logic [15:0] win,
                     input logic [15:0] len, output bit acc);
    i_seq_number  = seq;
    i_ack_number  = ack;
    i_flags       = fl;
    i_window_size = win;
    i_payload_len = len;
    i_hdr_valid   = 1'b1;
    #1;
    acc = (o_hdr_ack === 1'b1);
    tick();
    i_hdr_valid = 1'b0;
  endtask

  task automatic ack_req();
    i_tx_ctrl_ack = 1'b1;
    tick();
    i_tx_ctrl_ack = 1'b0;
  endtask

  task automatic stream(input int n, input bit fwd, input bit bp,
                        output int got, output int bad,
                        output bit fin_seen);
    int idx;
    idx = 0;
    got = 0;
    bad = 0;
    fin_seen = 1'b0;
    for (int c = 0; c < 40 && idx < n; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'hA0 + idx[7:0];
      s_if.tlast  = (idx == n - 1);
      m_if.tready = bp ? c[0] : 1'b1;
      #1;
      if (m_if.tvalid !== fwd) bad++;
      if (fwd && m_if.tdata !== s_if.tdata) bad++;
      if (fwd && m_if.tlast !== s_if.tlast) bad++;
      if (s_if.tready !== (fwd ? m_if.tready : 1'b1)) bad++;
      if (o_fin_rcvd === 1'b1) begin
        if (s_if.tlast && m_if.tready) fin_seen = 1'b1;
        else bad++;
      end
      if (s_if.tready === 1'b1) begin
        idx++;
        got++;
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    n_chk++;
    if (o_ack_number !== 32'd0 || o_synced !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: ack=%h synced=%b want 0/0",
               o_ack_number, o_synced);
    end
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b0 || o_tx_ctrl !== TX_CTRL_SEND_SYN ||
        s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: txv=%b tx=%0d trdy=%b mval=%b want 0",
               o_tx_ctrl_valid, o_tx_ctrl, s_if.tready, m_if.tvalid);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_unsynced();
    bit acc;
    hdr(32'h10, 32'h0, 8'h10, 16'h0, 16'd0, acc);
    tick();
    n_chk++;
    if (!acc || o_tx_ctrl_valid !== 1'b0 || o_hdr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL unsynced_len0: acc=%b txv=%b want 1/0",
               acc, o_tx_ctrl_valid);
    end
  endtask

  task automatic test_syn();
    bit acc;
    hdr(32'h1000_0000, 32'hAA, 8'h02, 16'h100, 16'd0, acc);
    n_chk++;
    if (!acc || o_syn_rcvd !== 1'b1) begin
      n_fail++;
      $display("FAIL syn_pulse: acc=%b syn=%b want 1/1", acc, o_syn_rcvd);
    end
    tick();
    n_chk++;
    if (o_ack_number !== 32'h1000_0001 || o_synced !== 1'b1) begin
      n_fail++;
      $display("FAIL syn_rcvnxt: got %h want 10000001", o_ack_number);
    end
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b1 || o_tx_ctrl !== TX_CTRL_SEND_ACK) begin
      n_fail++;
      $display("FAIL syn_req: valid=%b ctrl=%0d want 1/%0d",
               o_tx_ctrl_valid, o_tx_ctrl, TX_CTRL_SEND_ACK);
    end
    i_hdr_valid = 1'b1;
    tick();
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b1 || o_hdr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL syn_hold: valid=%b hdr_ack=%b want 1/0",
               o_tx_ctrl_valid, o_hdr_ack);
    end
    i_hdr_valid = 1'b0;
    ack_req();
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL syn_release: valid=%b want 0", o_tx_ctrl_valid);
    end
  endtask

  task automatic test_forward();
    bit acc;
    bit fs;
    int got;
    int bad;
    hdr(32'h1000_0001, 32'h55, 8'h18, 16'h200, 16'd4, acc);
    tick();
    stream(4, 1'b1, 1'b1, got, bad, fs);
    n_chk++;
    if (!acc || got !== 4 || bad !== 0) begin
      n_fail++;
      $display("FAIL fwd_beats: acc=%b got=%0d bad=%0d want 1/4/0",
               acc, got, bad);
    end
    n_chk++;
    if (o_ack_number !== 32'h1000_0005) begin
      n_fail++;
      $display("FAIL fwd_rcvnxt: got %h want 10000005", o_ack_number);
    end
    n_chk++;
    if (o_peer_ack !== 32'h55 || o_peer_window !== 16'h200) begin
      n_fail++;
      $display("FAIL fwd_peer: ack=%h win=%h want 55/200",
               o_peer_ack, o_peer_window);
    end
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b1 || s_if.tready !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_req: valid=%b trdy=%b want 1/0",
               o_tx_ctrl_valid, s_if.tready);
    end
    ack_req();
  endtask

  task automatic test_dup();
    bit acc;
    bit fs;
    int got;
    int bad;
    hdr(32'h1000_000D, 32'h99, 8'h10, 16'h300, 16'd3, acc);
    tick();
    stream(3, 1'b0, 1'b0, got, bad, fs);
    n_chk++;
    if (!acc || got !== 3 || bad !== 0) begin
      n_fail++;
      $display("FAIL dup_drain: acc=%b got=%0d bad=%0d want 1/3/0",
               acc, got, bad);
    end
    n_chk++;
    if (o_ack_number !== 32'h1000_0005 || o_peer_ack !== 32'h55) begin
      n_fail++;
      $display("FAIL dup_state: rcv=%h peer=%h want 10000005/55",
               o_ack_number, o_peer_ack);
    end
    n_chk++;
    if (o_tx_ctrl_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dup_req: valid=%b want 1", o_tx_ctrl_valid);
    end
    ack_req();
  endtask

  task automatic test_fin();
    bit acc;
    bit fs;
    int got;
    int bad;
    hdr(32'h1000_0005, 32'h56, 8'h11, 16'h200, 16'd2, acc);
    n_chk++;
    if (!acc || o_fin_rcvd !== 1'b0) begin
      n_fail++;
      $display("FAIL fin_check: acc=%b fin=%b want 1/0", acc, o_fin_rcvd);
    end
    tick();
    stream(2, 1'b1, 1'b0, got, bad, fs);
    n_chk++;
    if (got !== 2 || bad !== 0 || fs !== 1'b1) begin
      n_fail++;
      $display("FAIL fin_pulse: got=%0d bad=%0d fin=%b want 2/0/1",
               got, bad, fs);
    end
    n_chk++;
    if (o_ack_number !== 32'h1000_0008 || o_tx_ctrl_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fin_rcvnxt: rcv=%h valid=%b want 10000008/1",
               o_ack_number, o_tx_ctrl_valid);
    end
    ack_req();
  endtask

  task automatic test_rst();
    bit acc;
    bit fs;
    int got;
    int bad;
    hdr(32'h1000_0008, 32'h0, 8'h04, 16'h0, 16'd0, acc);
    n_chk++;
    if (!acc || o_rst_rcvd !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pulse: acc=%b rst=%b want 1/1", acc, o_rst_rcvd);
    end
    tick();
    n_chk++;
    if (o_synced !== 1'b0 || o_tx_ctrl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state: synced=%b valid=%b want 0/0",
               o_synced, o_tx_ctrl_valid);
    end
    hdr(32'h1000_0008, 32'h0, 8'h18, 16'h0, 16'd2, acc);
    tick();
    stream(2, 1'b0, 1'b0, got, bad, fs);
    n_chk++;
    if (got !== 2 || bad !== 0 || o_tx_ctrl_valid !== 1'b0 ||
        o_ack_number !== 32'h1000_0008) begin
      n_fail++;
      $display("FAIL rst_drop: got=%0d bad=%0d valid=%b rcv=%h want 2/0/0/10000008",
               got, bad, o_tx_ctrl_valid, o_ack_number);
    end
    hdr(32'hFFFF_FFFF, 32'h7, 8'h02, 16'h40, 16'd0, acc);
    tick();
    n_chk++;
    if (o_ack_number !== 32'h0 || o_synced !== 1'b1 ||
        o_tx_ctrl_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL syn_wrap: rcv=%h synced=%b valid=%b want 0/1/1",
               o_ack_number, o_synced, o_tx_ctrl_valid);
    end
    ack_req();
  endtask

  task automatic test_reset_mid_forward();
    bit acc;
    hdr(32'h0, 32'h0, 8'h18, 16'h0, 16'd4, acc);
    tick();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h33;
    m_if.tready = 1'b1;
    #1;
    n_chk++;
    if (m_if.tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fwd: mval=%b want 1", m_if.tvalid);
    end
    #1;
    i_rst = 1'b1;
    #1;
    n_chk++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 ||
        o_ack_number !== 32'h0 || o_synced !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: mval=%b trdy=%b rcv=%h sync=%b want 0",
               m_if.tvalid, s_if.tready, o_ack_number, o_synced);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    hdr(32'h20, 32'h0, 8'h02, 16'h0, 16'd0, acc);
    tick();
    n_chk++;
    if (!acc || o_ack_number !== 32'h21 || o_tx_ctrl_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst: acc=%b rcv=%h valid=%b want 1/21/1",
               acc, o_ack_number, o_tx_ctrl_valid);
    end
    ack_req();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst         = 1'b1;
    i_seq_number  = '0;
    i_ack_number  = '0;
    i_flags       = '0;
    i_window_size = '0;
    i_payload_len = '0;
    i_hdr_valid   = 1'b0;
    i_tx_ctrl_ack = 1'b0;
    s_if.tvalid   = 1'b0;
    s_if.tdata    = '0;
    s_if.tlast    = 1'b0;
    m_if.tready   = 1'b0;
    test_reset();
    test_unsynced();
    test_syn();
    test_forward();
    test_dup();
    test_fin();
    test_rst();
    test_reset_mid_forward();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
